// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Parses command frames arriving through a UART RX FIFO, loads operand and
//   opcode registers for an external combinational ALU, captures the result
//   and answers through the UART TX FIFO.
//
//   Frame (CMD_CHECKSUM_EN defined):   HDR_BYTE, A, B, OP, CHK
//   Frame (CMD_CHECKSUM_EN undefined): HDR_BYTE, A, B, OP
//   CHK must equal A ^ B ^ zero-extended OP. Good frame -> ACK_BYTE, result.
//   Bad checksum -> ERR_BYTE. Inter-byte gap of TIMEOUT_CYC cycles -> abort.
//
//   Ports:
//     clock         system clock
//     i_reset       asynchronous active-low reset
//     i_rx_empty    RX FIFO empty
//     i_rx_data     RX FIFO head word
//     o_rd_uart     RX FIFO pop strobe
//     i_tx_full     TX FIFO full
//     o_wr_uart     TX FIFO push strobe
//     o_tx_data     byte pushed into the TX FIFO (registered)
//     o_alu_a/b     registered operands
//     o_alu_op      registered opcode
//     i_alu_result  combinational ALU result
//     o_busy        high whenever a frame is in progress
//     o_err         one-cycle pulse on checksum error or timeout
//
//   Build macro: CMD_CHECKSUM_EN enables the trailing checksum byte.
module uart_cmd_sequencer #(
    parameter int              DBIT        = 8,
    parameter int              NB_OP       = 6,
    parameter int              TIMEOUT_CYC = 100000,
    parameter logic [DBIT-1:0] HDR_BYTE    = 8'hA5,
    parameter logic [DBIT-1:0] ACK_BYTE    = 8'h5A,
    parameter logic [DBIT-1:0] ERR_BYTE    = 8'hEE
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_rx_data,
    output logic             o_rd_uart,
    input  logic             i_tx_full,
    output logic             o_wr_uart,
    output logic [DBIT-1:0]  o_tx_data,
    output logic [DBIT-1:0]  o_alu_a,
    output logic [DBIT-1:0]  o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic             o_busy,
    output logic             o_err
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_OP,
        GET_CHK,
        EXEC,
        SEND_ACK,
        SEND_RES,
        SEND_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [DBIT-1:0]   a_q, a_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [NB_OP-1:0]  op_q, op_d;
    logic [DBIT-1:0]   res_q, res_d;
    logic [DBIT-1:0]   tx_q, tx_d;
    logic [CW-1:0]     to_cnt_q, to_cnt_d;

    logic in_get;
    logic pop;
    logic timeout;
    logic rd_c;
    logic wr_c;
    logic err_c;

`ifdef CMD_CHECKSUM_EN
    logic [DBIT-1:0] chk_exp;
    assign chk_exp = a_q ^ b_q ^ DBIT'(op_q);
`endif

    assign in_get  = (state_q == GET_A) || (state_q == GET_B) ||
                     (state_q == GET_OP) || (state_q == GET_CHK);
    assign pop     = ((state_q == IDLE) || in_get) && !i_rx_empty;
    // A pop always wins over the terminal count: timeout requires an empty FIFO.
    assign timeout = in_get && i_rx_empty && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        tx_d     = tx_q;
        to_cnt_d = '0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        err_c    = 1'b0;

        if (in_get && i_rx_empty && !timeout) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        rd_c = pop;

        unique case (state_q)
            IDLE: begin
                if (pop && (i_rx_data == HDR_BYTE)) begin
                    state_d = GET_A;
                end
            end
            GET_A: begin
                if (pop) begin
                    a_d     = i_rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (pop) begin
                    b_d     = i_rx_data;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (pop) begin
                    op_d = i_rx_data[NB_OP-1:0];
`ifdef CMD_CHECKSUM_EN
                    state_d = GET_CHK;
`else
                    state_d = EXEC;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            GET_CHK: begin
                if (pop) begin
                    if (i_rx_data == chk_exp) begin
                        state_d = EXEC;
                    end else begin
                        err_c   = 1'b1;
                        tx_d    = ERR_BYTE;
                        state_d = SEND_ERR;
                    end
                end
            end
`endif
            EXEC: begin
                res_d   = i_alu_result;
                tx_d    = ACK_BYTE;
                state_d = SEND_ACK;
            end
            SEND_ACK: begin
                if (!i_tx_full) begin
                    wr_c    = 1'b1;
                    // Preload the result so it is already registered when pushed.
                    tx_d    = res_q;
                    state_d = SEND_RES;
                end
            end
            SEND_RES: begin
                if (!i_tx_full) begin
                    wr_c    = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND_ERR: begin
                if (!i_tx_full) begin
                    wr_c    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            err_c   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            tx_q     <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            tx_q     <= tx_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Strobes are decoded from state and FIFO flags; gate them so that an
    // asserted reset silences them even while the FIFO reports data.
    assign o_rd_uart = rd_c & i_reset;
    assign o_wr_uart = wr_c & i_reset;
    assign o_err     = err_c & i_reset;
    assign o_busy    = (state_q != IDLE);
    assign o_tx_data = tx_q;
    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_op  = op_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: an RX FIFO model feeds bytes, a frame-level
// model predicts the TX byte stream and error pulses, and a per-cycle check
// compares every push, pop and error pulse against it.
module tb_uart_cmd_sequencer;

`ifdef CMD_CHECKSUM_EN
    localparam bit CHK_ON    = 1'b1;
    localparam int FRAME_LEN = 5;
`else
    localparam bit CHK_ON    = 1'b0;
    localparam int FRAME_LEN = 4;
`endif

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_empty = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_tx_full = 1'b0;
    logic [7:0] i_alu_result;
    logic       o_rd_uart, o_wr_uart, o_busy, o_err;
    logic [7:0] o_tx_data, o_alu_a, o_alu_b;
    logic [5:0] o_alu_op;

    always #5 clock = ~clock;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    uart_cmd_sequencer #(
        .DBIT(8),
        .NB_OP(6),
        .TIMEOUT_CYC(16),
        .HDR_BYTE(8'hA5),
        .ACK_BYTE(8'h5A),
        .ERR_BYTE(8'hEE)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_rx_empty(i_rx_empty),
        .i_rx_data(i_rx_data),
        .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full),
        .o_wr_uart(o_wr_uart),
        .o_tx_data(o_tx_data),
        .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b),
        .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_buf [256];
    int rx_wr = 0, rx_rd = 0;
    logic [7:0] exp_tx [256];
    int exp_wr = 0, exp_rd = 0;
    logic [7:0] got_tx [256];
    int n_got = 0;
    int n_pop = 0, last_pop_cyc = -1;
    int err_seen = 0, err_exp = 0, err_cyc = -1;
    int first_push_cyc = -1;
    bit pop_flag = 1'b0;
    bit t_rst = 1'b0;
    bit t_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[rx_wr[7:0]] = b;
        rx_wr++;
    endtask

    task automatic expect_tx(input logic [7:0] b);
        exp_tx[exp_wr[7:0]] = b;
        exp_wr++;
    endtask

    // Frame-level model: a frame either yields ACK + ALU result, or ERR and
    // one error pulse when the checksum byte does not match.
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] opb, input logic [7:0] chk);
        logic [5:0] op;
        op = opb[5:0];
        push(8'hA5); push(a); push(b); push(opb);
        if (CHK_ON) push(chk);
        if (CHK_ON && (chk != (a ^ b ^ {2'b00, op}))) begin
            expect_tx(8'hEE);
            err_exp++;
        end else begin
            expect_tx(8'h5A);
            expect_tx(alu_ref(a, b, op));
        end
    endtask

    // One clock cycle: apply inputs just after the rising edge, sample and
    // check everything on the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (pop_flag) rx_rd++;
        i_reset    = t_rst;
        i_tx_full  = t_full;
        i_rx_empty = (rx_rd == rx_wr);
        i_rx_data  = i_rx_empty ? 8'h00 : rx_buf[rx_rd[7:0]];
        @(negedge clock);
        cyc++;
        pop_flag = o_rd_uart;
        if (!i_reset) begin
            check("reset_strobes", 32'({o_rd_uart, o_wr_uart, o_err, o_busy}), 32'h0);
            check("reset_data", {o_tx_data, o_alu_a, o_alu_b, 2'b00, o_alu_op}, 32'h0);
        end
        if (o_rd_uart) begin
            n_pop++;
            last_pop_cyc = cyc;
            check("pop_when_nonempty", 32'(i_rx_empty), 32'h0);
        end
        if (o_wr_uart) begin
            check("push_when_not_full", 32'(i_tx_full), 32'h0);
            if (exp_rd < exp_wr) begin
                check("tx_byte", 32'(o_tx_data), 32'(exp_tx[exp_rd[7:0]]));
                exp_rd++;
            end else begin
                check("tx_unexpected_push", 32'(o_wr_uart), 32'h0);
            end
            got_tx[n_got[7:0]] = o_tx_data;
            n_got++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        if (o_err) begin
            err_seen++;
            err_cyc = cyc;
            check("err_expected", 32'(err_seen <= err_exp), 32'h1);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (rx_rd == rx_wr) && (exp_rd == exp_wr) && !o_busy;
        end
        check({name, "_completed"}, 32'(done), 32'h1);
        check({name, "_err_count"}, err_seen, err_exp);
    endtask

    initial begin
        int p0, g0, e0, ec0, rel;
        bit found;

        // Reset state
        repeat (3) step();
        t_rst = 1'b1;
        step();
        check("post_reset_busy", 32'(o_busy), 32'h0);
        check("post_reset_alu_a", 32'(o_alu_a), 32'h0);
        check("post_reset_tx_data", 32'(o_tx_data), 32'h0);

        // Good frame, add
        p0 = n_pop; g0 = n_got; e0 = err_seen;
        push_frame(8'h22, 8'h07, 8'h20, 8'h05);
        wait_idle("good_add", 200);
        check("good_add_pops", n_pop - p0, FRAME_LEN);
        check("good_add_push_count", n_got - g0, 2);
        check("good_add_ack", 32'(got_tx[g0[7:0]]), 32'h5A);
        check("good_add_res", 32'(got_tx[(g0 + 1) & 255]), 32'h29);
        check("good_add_no_err", err_seen - e0, 0);
        check("operands_held", {8'h00, o_alu_a, o_alu_b, 2'b00, o_alu_op}, 32'h0022_0720);

        // Same frame, wrong checksum (only an error when checksum is built in)
        g0 = n_got; e0 = err_seen; ec0 = err_cyc;
        push_frame(8'h22, 8'h07, 8'h20, 8'h00);
        wait_idle("bad_chk", 200);
        check("bad_chk_push_count", n_got - g0, CHK_ON ? 1 : 2);
        check("bad_chk_first", 32'(got_tx[g0[7:0]]), CHK_ON ? 32'hEE : 32'h5A);
        check("bad_chk_err_pulses", err_seen - e0, CHK_ON ? 1 : 0);
        check("bad_chk_err_with_pop", err_cyc, CHK_ON ? last_pop_cyc : ec0);

        // Junk bytes ahead of the header
        p0 = n_pop; g0 = n_got;
        push(8'h11); push(8'h22);
        push_frame(8'h03, 8'h04, 8'h20, 8'h27);
        wait_idle("junk", 200);
        check("junk_pops", n_pop - p0, FRAME_LEN + 2);
        check("junk_ack", 32'(got_tx[g0[7:0]]), 32'h5A);
        check("junk_res", 32'(got_tx[(g0 + 1) & 255]), 32'h07);

        // Opcode upper bits ignored, and a subtract
        g0 = n_got;
        push_frame(8'h01, 8'h02, 8'hE0, 8'h23);
        wait_idle("op_mask", 200);
        check("op_mask_opcode", 32'(o_alu_op), 32'h20);
        check("op_mask_res", 32'(got_tx[(g0 + 1) & 255]), 32'h03);
        push_frame(8'h09, 8'h03, 8'h22, 8'h28);
        wait_idle("sub", 200);
        check("sub_res", 32'(got_tx[(g0 + 3) & 255]), 32'h06);

        // TX FIFO full while the ACK is pending
        g0 = n_got;
        t_full = 1'b1;
        push_frame(8'h02, 8'h03, 8'h20, 8'h21);
        repeat (60) step();
        check("full_no_push", n_got - g0, 0);
        check("full_busy", 32'(o_busy), 32'h1);
        check("full_tx_data_held", 32'(o_tx_data), 32'h5A);
        first_push_cyc = -1;
        t_full = 1'b0;
        step();
        rel = cyc;
        wait_idle("full_release", 200);
        check("full_push_on_release", first_push_cyc, rel);
        check("full_ack", 32'(got_tx[g0[7:0]]), 32'h5A);
        check("full_res", 32'(got_tx[(g0 + 1) & 255]), 32'h05);

        // Inter-byte timeout (TIMEOUT_CYC = 16)
        g0 = n_got; e0 = err_seen;
        push(8'hA5); push(8'h01);
        err_exp++;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = (err_seen > e0);
        end
        check("timeout_seen", 32'(found), 32'h1);
        check("timeout_gap", err_cyc - last_pop_cyc, 16);
        step();
        check("timeout_idle", 32'(o_busy), 32'h0);
        check("timeout_no_push", n_got - g0, 0);
        check("timeout_alu_a", 32'(o_alu_a), 32'h01);

        // Reset pulse in GET_B, then a clean frame
        p0 = n_pop;
        push(8'hA5); push(8'h02);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (n_pop - p0 == 2);
        end
        check("midframe_pops", 32'(found), 32'h1);
        step(); step();
        check("midframe_busy", 32'(o_busy), 32'h1);
        t_rst = 1'b0;
        step();
        check("midframe_reset_busy", 32'(o_busy), 32'h0);
        check("midframe_reset_alu_a", 32'(o_alu_a), 32'h0);
        t_rst = 1'b1;
        p0 = n_pop; g0 = n_got;
        push_frame(8'h02, 8'h03, 8'h20, 8'h21);
        wait_idle("after_reset", 200);
        check("after_reset_pops", n_pop - p0, FRAME_LEN);
        check("after_reset_ack", 32'(got_tx[g0[7:0]]), 32'h5A);
        check("after_reset_res", 32'(got_tx[(g0 + 1) & 255]), 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
